// File: rtl/snitch_cluster_perf_sampler_pkg.sv
// Shared types and constants for the performance-counter sampler.
// The default register-bus structs use a 32-bit address.
package snitch_cluster_perf_sampler_pkg;

    localparam int unsigned SampleWidth = 48;
    localparam int unsigned WordWidth   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_RD_HI2,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/snitch_cluster_perf_sampler_reader.sv
// Single-read register-bus engine: holds valid/addr until ready, then pulses done.
// Handshake: valid stays high with a stable addr until a cycle with ready=1; rdata/error are taken in that cycle.
module snitch_cluster_perf_sampler_reader
    import snitch_cluster_perf_sampler_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter type         req_t     = snitch_cluster_perf_sampler_pkg::reg_req_t,
    parameter type         rsp_t     = snitch_cluster_perf_sampler_pkg::reg_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] addr_i,
    output req_t                 req_o,
    input  rsp_t                 rsp_i,
    output logic                 done_o,
    output logic [WordWidth-1:0] rdata_o,
    output logic                 error_o
);

    logic                 valid_q;
    logic [AddrWidth-1:0] addr_q;

    // A start in the completion cycle launches the next read back-to-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (start_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
        end else if (valid_q && rsp_i.ready) begin
            valid_q <= 1'b0;
        end
    end

    always_comb begin
        req_o       = '0;
        req_o.addr  = addr_q;
        req_o.valid = valid_q;
    end

    assign done_o  = valid_q & rsp_i.ready;
    assign rdata_o = rsp_i.rdata;
    assign error_o = rsp_i.error;

endmodule

// File: rtl/snitch_cluster_perf_sampler.sv
// Sweeps the cluster's 48-bit counters as hi/lo/hi reads and emits tear-free samples on a stream.
// Stream: sample_valid_o holds with stable data until sample_ready_i is high in the same cycle.
module snitch_cluster_perf_sampler
    import snitch_cluster_perf_sampler_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          NumCounters   = 16,
    parameter logic [AddrWidth-1:0] CounterBase   = '0,
    parameter int unsigned          CounterStride = 8,
    parameter int unsigned          MaxRetries    = 3,
    parameter type                  reg_req_t     = snitch_cluster_perf_sampler_pkg::reg_req_t,
    parameter type                  reg_rsp_t     = snitch_cluster_perf_sampler_pkg::reg_rsp_t,
    parameter int unsigned          IdxWidth      = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    input  logic                   enable_i,
    input  logic [31:0]            period_i,
    input  logic                   trigger_i,
    output logic [SampleWidth-1:0] sample_o,
    output logic [IdxWidth-1:0]    sample_idx_o,
    output logic                   sample_torn_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic                   busy_o,
    output logic                   err_o,
    output state_e                 dbg_state_o
);

    localparam int unsigned        RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumCounters - 1);

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic [WordWidth-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [RetryWidth-1:0]  retries_q, retries_d;
    logic                   torn_q, torn_d, err_q, err_d;
    logic [31:0]            cnt_q, cnt_d;

    logic                   rd_start, rd_hi_sel, rd_done, rd_error, advance;
    logic [WordWidth-1:0]   rd_rdata;
    logic [AddrWidth-1:0]   rd_addr;

    assign rd_addr = CounterBase + AddrWidth'(idx_d) * AddrWidth'(CounterStride)
                   + (rd_hi_sel ? AddrWidth'(4) : '0);

    snitch_cluster_perf_sampler_reader #(
        .AddrWidth (AddrWidth),
        .req_t     (reg_req_t),
        .rsp_t     (reg_rsp_t)
    ) i_reader (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (rd_start),
        .addr_i  (rd_addr),
        .req_o   (reg_req_o),
        .rsp_i   (reg_rsp_i),
        .done_o  (rd_done),
        .rdata_o (rd_rdata),
        .error_o (rd_error)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        retries_d = retries_q;
        torn_d    = torn_q;
        err_d     = err_q;
        rd_start  = 1'b0;
        rd_hi_sel = 1'b0;
        advance   = 1'b0;
        cnt_d     = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (!enable_i) cnt_d = 32'd0;
                if (trigger_i || (enable_i && cnt_q == 32'd0)) begin
                    state_d   = ST_RD_HI;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    retries_d = '0;
                    torn_d    = 1'b0;
                    // The start cycle itself counts as the first of the period.
                    cnt_d     = (period_i != 32'd0) ? period_i - 32'd1 : 32'd0;
                    rd_start  = 1'b1;
                    rd_hi_sel = 1'b1;
                end
            end
            ST_RD_HI: begin
                if (rd_done) begin
                    if (rd_error) begin
                        advance = 1'b1;
                    end else begin
                        hi_d     = rd_rdata;
                        state_d  = ST_RD_LO;
                        rd_start = 1'b1;
                    end
                end
            end
            ST_RD_LO: begin
                if (rd_done) begin
                    if (rd_error) begin
                        advance = 1'b1;
                    end else begin
                        lo_d      = rd_rdata;
                        state_d   = ST_RD_HI2;
                        rd_start  = 1'b1;
                        rd_hi_sel = 1'b1;
                    end
                end
            end
            ST_RD_HI2: begin
                if (rd_done) begin
                    if (rd_error) begin
                        advance = 1'b1;
                    end else begin
                        // The latest high word is kept whether it matched, retries or tears.
                        hi_d = rd_rdata;
                        if (rd_rdata == hi_q) begin
                            torn_d  = 1'b0;
                            state_d = ST_EMIT;
                        end else if (retries_q < RetryWidth'(MaxRetries)) begin
                            retries_d = retries_q + RetryWidth'(1);
                            state_d   = ST_RD_LO;
                            rd_start  = 1'b1;
                        end else begin
                            torn_d  = 1'b1;
                            state_d = ST_EMIT;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (sample_ready_i) advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (rd_done && rd_error) err_d = 1'b1;
            if (idx_q == LastIdx) begin
                state_d = ST_IDLE;
            end else begin
                idx_d     = idx_q + IdxWidth'(1);
                retries_d = '0;
                torn_d    = 1'b0;
                state_d   = ST_RD_HI;
                rd_start  = 1'b1;
                rd_hi_sel = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            retries_q <= '0;
            torn_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            retries_q <= retries_d;
            torn_q    <= torn_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sample_o       = {hi_q[15:0], lo_q};
    assign sample_idx_o   = idx_q;
    assign sample_torn_o  = torn_q;
    assign sample_valid_o = (state_q == ST_EMIT);
    assign busy_o         = (state_q != ST_IDLE);
    assign err_o          = err_q;
    assign dbg_state_o    = state_q;

endmodule
